// File: rtl/clk_div_sequencer.sv
// Programmable clock-enable divider/sequencer: one counter drives the divided level and
// the edge strobes; config changes land only on period boundaries and stops finish the period.
module clk_div_sequencer #(
    parameter int WIDTH      = 8,
    parameter int RESET_DIV  = 4,
    parameter int RESET_HIGH = 2
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_err,
    output logic             clk_level,
    output logic             preedge,
    output logic             edge_pulse,
    output logic             running,
    output logic [WIDTH-1:0] cur_div
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PEND  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] L_ZERO       = '0;
    localparam logic [WIDTH-1:0] L_ONE        = WIDTH'(32'd1);
    localparam logic [WIDTH-1:0] L_TWO        = WIDTH'(32'd2);
    localparam logic [WIDTH-1:0] L_RESET_DIV  = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] L_RESET_HIGH = WIDTH'(RESET_HIGH);

    function automatic logic f_cfg_ok(input logic [WIDTH-1:0] div, input logic [WIDTH-1:0] high);
        return (div >= L_TWO) && (high != L_ZERO) && (high < div);
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_cur_div;
    logic [WIDTH-1:0] r_cur_high;
    logic [WIDTH-1:0] r_shd_div;
    logic [WIDTH-1:0] r_shd_high;
    logic             r_shd_full;
    logic             r_cfg_err;
    logic             r_clk_level;
    logic             r_edge_pulse;
    logic             r_running;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_cur_div_nxt;
    logic [WIDTH-1:0] w_cur_high_nxt;
    logic [WIDTH-1:0] w_shd_div_nxt;
    logic [WIDTH-1:0] w_shd_high_nxt;
    logic             w_shd_full_nxt;
    logic             w_xfer;
    logic             w_cfg_ok;
    logic             w_accept;
    logic             w_boundary;
    logic             w_run_type_nxt;

    assign cfg_ready      = (r_state == ST_STOP) || (r_state == ST_RUN);
    assign w_xfer         = cfg_valid && cfg_ready;
    assign w_cfg_ok       = f_cfg_ok(cfg_div, cfg_high);
    assign w_accept       = w_xfer && w_cfg_ok;
    assign w_boundary     = (r_state != ST_STOP) && (r_cnt == (r_cur_div - L_ONE));
    assign w_run_type_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PEND);

    // Next-state, counter, current-config and shadow update
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cur_div_nxt  = r_cur_div;
        w_cur_high_nxt = r_cur_high;
        w_shd_div_nxt  = r_shd_div;
        w_shd_high_nxt = r_shd_high;
        w_shd_full_nxt = r_shd_full;
        case (r_state)
            ST_STOP: begin
                w_cnt_nxt = L_ZERO;
                if (w_accept) begin
                    w_cur_div_nxt  = cfg_div;
                    w_cur_high_nxt = cfg_high;
                end else begin
                    w_cur_div_nxt = r_cur_div;
                end
                if (enable) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_RUN: begin
                if (w_boundary) begin
                    w_cnt_nxt = L_ZERO;
                    if (enable) begin
                        if (w_accept) begin
                            w_shd_div_nxt  = cfg_div;
                            w_shd_high_nxt = cfg_high;
                            w_shd_full_nxt = 1'b1;
                            w_state_nxt    = ST_PEND;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        // Stopping here: no period will run on the old values, so load directly
                        if (w_accept) begin
                            w_cur_div_nxt  = cfg_div;
                            w_cur_high_nxt = cfg_high;
                        end else begin
                            w_cur_div_nxt = r_cur_div;
                        end
                        w_state_nxt = ST_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + L_ONE;
                    if (w_accept) begin
                        w_shd_div_nxt  = cfg_div;
                        w_shd_high_nxt = cfg_high;
                        w_shd_full_nxt = 1'b1;
                    end else begin
                        w_shd_full_nxt = r_shd_full;
                    end
                    if (!enable) begin
                        w_state_nxt = ST_DRAIN;
                    end else if (w_accept) begin
                        w_state_nxt = ST_PEND;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_PEND: begin
                if (w_boundary) begin
                    w_cnt_nxt      = L_ZERO;
                    w_cur_div_nxt  = r_shd_div;
                    w_cur_high_nxt = r_shd_high;
                    w_shd_full_nxt = 1'b0;
                    if (enable) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + L_ONE;
                    if (!enable) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_PEND;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_boundary) begin
                    w_cnt_nxt   = L_ZERO;
                    w_state_nxt = ST_STOP;
                    if (r_shd_full) begin
                        w_cur_div_nxt  = r_shd_div;
                        w_cur_high_nxt = r_shd_high;
                        w_shd_full_nxt = 1'b0;
                    end else begin
                        w_shd_full_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + L_ONE;
                end
            end
            default: begin
                w_state_nxt    = ST_STOP;
                w_cnt_nxt      = L_ZERO;
                w_shd_full_nxt = 1'b0;
            end
        endcase
    end

    // State, configuration and registered output update
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            r_state      <= ST_STOP;
            r_cnt        <= L_ZERO;
            r_cur_div    <= L_RESET_DIV;
            r_cur_high   <= L_RESET_HIGH;
            r_shd_div    <= L_ZERO;
            r_shd_high   <= L_ZERO;
            r_shd_full   <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_clk_level  <= 1'b0;
            r_edge_pulse <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cur_div    <= w_cur_div_nxt;
            r_cur_high   <= w_cur_high_nxt;
            r_shd_div    <= w_shd_div_nxt;
            r_shd_high   <= w_shd_high_nxt;
            r_shd_full   <= w_shd_full_nxt;
            r_cfg_err    <= w_xfer && !w_cfg_ok;
            r_running    <= (w_state_nxt != ST_STOP);
            r_edge_pulse <= w_run_type_nxt && (w_cnt_nxt == L_ZERO);
            r_clk_level  <= (w_state_nxt != ST_STOP) && (w_cnt_nxt < w_cur_high_nxt);
        end
    end

    // preedge depends on this cycle's enable, so it cannot be a registered copy
    assign preedge    = w_boundary && w_run_type_nxt;
    assign cfg_err    = r_cfg_err;
    assign clk_level  = r_clk_level;
    assign edge_pulse = r_edge_pulse;
    assign running    = r_running;
    assign cur_div    = r_cur_div;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed bench for clk_div_sequencer: inputs change 1 ns after each rising edge,
// outputs are checked in that same window against hand-derived values.
module tb_clk_div_sequencer;

    logic       CLK_IN = 1'b0;
    logic       RST = 1'b1;
    logic       enable = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_div = 8'd0;
    logic [7:0] cfg_high = 8'd0;
    logic       cfg_err;
    logic       clk_level;
    logic       preedge;
    logic       edge_pulse;
    logic       running;
    logic [7:0] cur_div;

    int checks = 0;
    int errors = 0;

    clk_div_sequencer #(.WIDTH(8), .RESET_DIV(4), .RESET_HIGH(2)) dut (
        .CLK_IN     (CLK_IN),
        .RST        (RST),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .cfg_high   (cfg_high),
        .cfg_err    (cfg_err),
        .clk_level  (clk_level),
        .preedge    (preedge),
        .edge_pulse (edge_pulse),
        .running    (running),
        .cur_div    (cur_div)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic step();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_level"}, {31'd0, clk_level}, 32'd0);
        chk({tag, "_pre"},   {31'd0, preedge},   32'd0);
        chk({tag, "_edge"},  {31'd0, edge_pulse}, 32'd0);
        chk({tag, "_err"},   {31'd0, cfg_err},   32'd0);
        chk({tag, "_run"},   {31'd0, running},   32'd0);
        chk({tag, "_rdy"},   {31'd0, cfg_ready}, 32'd1);
        chk({tag, "_div"},   {24'd0, cur_div},   32'd4);
    endtask

    task automatic set_cfg(input logic v, input logic [7:0] d, input logic [7:0] h);
        cfg_valid = v;
        cfg_div   = d;
        cfg_high  = h;
    endtask

    initial begin
        logic [3:0] lvl4;
        logic [2:0] lvl3;
        logic [5:0] lvl6;
        lvl4 = 4'b0011;
        lvl3 = 3'b011;
        lvl6 = 6'b000111;

        // Reset
        step();
        step();
        chk_reset_outputs("reset");
        RST = 1'b0;
        step();
        chk("stop_idle_run", {31'd0, running}, 32'd0);

        // 1: defaults div=4 high=2
        enable = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_level_%0d", i), {31'd0, clk_level}, {31'd0, lvl4[i % 4]});
            chk($sformatf("t1_edge_%0d", i), {31'd0, edge_pulse}, (i % 4 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t1_pre_%0d", i), {31'd0, preedge}, (i % 4 == 3) ? 32'd1 : 32'd0);
            chk($sformatf("t1_run_%0d", i), {31'd0, running}, 32'd1);
            step();
        end

        // 5: drop enable at cnt=1
        step();
        enable = 1'b0;
        chk("t5_pre_c1", {31'd0, preedge}, 32'd0);
        step();
        chk("t5_run_c2", {31'd0, running}, 32'd1);
        chk("t5_rdy_c2", {31'd0, cfg_ready}, 32'd0);
        chk("t5_level_c2", {31'd0, clk_level}, 32'd0);
        step();
        chk("t5_pre_c3", {31'd0, preedge}, 32'd0);
        chk("t5_run_c3", {31'd0, running}, 32'd1);
        step();
        chk("t5_stop_run", {31'd0, running}, 32'd0);
        chk("t5_stop_level", {31'd0, clk_level}, 32'd0);
        chk("t5_stop_edge", {31'd0, edge_pulse}, 32'd0);
        chk("t5_stop_rdy", {31'd0, cfg_ready}, 32'd1);
        step();
        chk("t5_stays_stop", {31'd0, running}, 32'd0);

        // 2: cfg in STOP, then enable
        set_cfg(1'b1, 8'd3, 8'd2);
        chk("t2_rdy", {31'd0, cfg_ready}, 32'd1);
        step();
        set_cfg(1'b0, 8'd0, 8'd0);
        chk("t2_div", {24'd0, cur_div}, 32'd3);
        chk("t2_err", {31'd0, cfg_err}, 32'd0);
        chk("t2_run", {31'd0, running}, 32'd0);
        enable = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2_level_%0d", i), {31'd0, clk_level}, {31'd0, lvl3[i % 3]});
            chk($sformatf("t2_edge_%0d", i), {31'd0, edge_pulse}, (i % 3 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t2_pre_%0d", i), {31'd0, preedge}, (i % 3 == 2) ? 32'd1 : 32'd0);
            step();
        end

        // Back to div=4 via a run-time change at cnt=0 of a div=3 period
        set_cfg(1'b1, 8'd4, 8'd2);
        chk("r4_rdy", {31'd0, cfg_ready}, 32'd1);
        step();
        set_cfg(1'b0, 8'd0, 8'd0);
        chk("r4_pend_rdy", {31'd0, cfg_ready}, 32'd0);
        chk("r4_pend_div", {24'd0, cur_div}, 32'd3);
        step();
        chk("r4_pre", {31'd0, preedge}, 32'd1);
        step();
        chk("r4_div", {24'd0, cur_div}, 32'd4);
        chk("r4_edge", {31'd0, edge_pulse}, 32'd1);
        chk("r4_level", {31'd0, clk_level}, 32'd1);

        // 3: cfg div=6 high=3 at cnt=1 of a div=4 period
        step();
        set_cfg(1'b1, 8'd6, 8'd3);
        chk("t3_rdy_c1", {31'd0, cfg_ready}, 32'd1);
        step();
        set_cfg(1'b0, 8'd0, 8'd0);
        chk("t3_rdy_c2", {31'd0, cfg_ready}, 32'd0);
        chk("t3_level_c2", {31'd0, clk_level}, 32'd0);
        chk("t3_div_c2", {24'd0, cur_div}, 32'd4);
        step();
        chk("t3_rdy_c3", {31'd0, cfg_ready}, 32'd0);
        chk("t3_pre_c3", {31'd0, preedge}, 32'd1);
        chk("t3_level_c3", {31'd0, clk_level}, 32'd0);
        step();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t3_level_%0d", i), {31'd0, clk_level}, {31'd0, lvl6[i]});
            chk($sformatf("t3_edge_%0d", i), {31'd0, edge_pulse}, (i == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t3_div_%0d", i), {24'd0, cur_div}, 32'd6);
            chk($sformatf("t3_rdy_%0d", i), {31'd0, cfg_ready}, 32'd1);
            step();
        end

        // 4: invalid configs while running at div=6
        set_cfg(1'b1, 8'd5, 8'd5);
        chk("t4a_rdy", {31'd0, cfg_ready}, 32'd1);
        step();
        set_cfg(1'b0, 8'd0, 8'd0);
        chk("t4a_err", {31'd0, cfg_err}, 32'd1);
        chk("t4a_div", {24'd0, cur_div}, 32'd6);
        chk("t4a_level", {31'd0, clk_level}, 32'd1);
        chk("t4a_rdy_after", {31'd0, cfg_ready}, 32'd1);
        step();
        chk("t4a_err_clear", {31'd0, cfg_err}, 32'd0);
        chk("t4a_level_c2", {31'd0, clk_level}, 32'd1);
        set_cfg(1'b1, 8'd1, 8'd1);
        step();
        set_cfg(1'b0, 8'd0, 8'd0);
        chk("t4b_err", {31'd0, cfg_err}, 32'd1);
        chk("t4b_div", {24'd0, cur_div}, 32'd6);
        chk("t4b_level", {31'd0, clk_level}, 32'd0);
        step();
        chk("t4b_err_clear", {31'd0, cfg_err}, 32'd0);
        chk("t4b_level_c4", {31'd0, clk_level}, 32'd0);
        step();
        chk("t4_pre_c5", {31'd0, preedge}, 32'd1);
        step();
        chk("t4_edge_c0", {31'd0, edge_pulse}, 32'd1);
        chk("t4_div_c0", {24'd0, cur_div}, 32'd6);

        // 6: reset while a shadow config is pending
        step();
        set_cfg(1'b1, 8'd2, 8'd1);
        step();
        set_cfg(1'b0, 8'd0, 8'd0);
        chk("t6_pend_rdy", {31'd0, cfg_ready}, 32'd0);
        RST = 1'b1;
        step();
        chk_reset_outputs("t6_rst");
        RST = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t6_level_%0d", i), {31'd0, clk_level}, {31'd0, lvl4[i % 4]});
            chk($sformatf("t6_div_%0d", i), {24'd0, cur_div}, 32'd4);
            chk($sformatf("t6_rdy_%0d", i), {31'd0, cfg_ready}, 32'd1);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
